// File: rtl/l1_i_refill_pkg.sv
// Shared constants and types for the L1-I line-fill engine.
// Contents: fill FSM state enum, beat count, line-address width, beat-count width.
package l1_i_refill_pkg;

    localparam int unsigned LINE_W_DEF = 512;
    localparam int unsigned BEAT_W_DEF = 128;
    localparam int unsigned BEATS      = LINE_W_DEF / BEAT_W_DEF;
    localparam int unsigned ADDR_W     = 26;
    localparam int unsigned CNT_W      = $clog2(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DONE,
        ST_DRAIN
    } refill_state_t;

endpackage

// File: rtl/l1_i_line_buffer.sv
// Line assembly buffer for the L1-I refill engine.
// Beats are written into a staging register; the completed line is copied
// to the output register only when the final beat arrives, so an aborted
// fill never disturbs the previously delivered line.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        zero the staging register
//   wr_en      write wr_data into beat slot wr_idx (slot 0 = LSBs)
//   commit     publish staging (including this cycle's beat) to line_o
//   line_o     last completed line
module l1_i_line_buffer #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned BEAT_W = 128,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              commit,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] stage_q, stage_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] merged;

    always_comb begin
        merged = stage_q;
        if (wr_en) begin
            merged[int'(wr_idx) * BEAT_W +: BEAT_W] = wr_data;
        end
        stage_d = clr ? '0 : merged;
        line_d  = commit ? merged : line_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            line_q  <= '0;
        end else begin
            stage_q <= stage_d;
            line_q  <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/l1_i_refill_unit.sv
// L1 instruction-cache line-fill engine.
// Accepts a miss from the L1-I controller, issues one line request to L2,
// assembles the returned beats into a full line and returns it with a
// single-cycle ready pulse. Handles flush (with drain of in-flight beats)
// and flags rsp_last protocol violations in a sticky err bit.
// Ports:
//   read_L1_L2/tag_L1_L2/index_L1_L2/way   miss request from L1-I
//   flush                                  abort current fill
//   req_valid/req_ready/req_addr           line request to L2
//   rsp_valid/rsp_data/rsp_last            L2 response beats
//   ready_L2_L1/line_L2_L1                 line return to L1-I
//   way_fill/index_fill                    latched fill target
//   busy, err                              status
module l1_i_refill_unit
    import l1_i_refill_pkg::*;
#(
    parameter int unsigned TNUM_2 = 18,
    parameter int unsigned INUM_2 = 8,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned BEAT_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read_L1_L2,
    input  logic [TNUM_2-1:0]        tag_L1_L2,
    input  logic [INUM_2-1:0]        index_L1_L2,
    input  logic                     way,
    input  logic                     flush,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [TNUM_2+INUM_2-1:0] req_addr,
    input  logic                     rsp_valid,
    input  logic [BEAT_W-1:0]        rsp_data,
    input  logic                     rsp_last,
    output logic                     ready_L2_L1,
    output logic [LINE_W-1:0]        line_L2_L1,
    output logic                     way_fill,
    output logic [INUM_2-1:0]        index_fill,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned    NBEATS   = LINE_W / BEAT_W;
    localparam int unsigned    CW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(NBEATS - 1);

    refill_state_t       state_q, state_d;
    logic [TNUM_2-1:0]   tag_q, tag_d;
    logic [INUM_2-1:0]   index_q, index_d;
    logic                way_q, way_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                hold_q, hold_d;
    logic                err_q, err_d;

    logic                same_addr;
    logic                final_beat;
    logic                buf_clr, buf_wr, buf_commit;

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        index_d     = index_q;
        way_d       = way_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        err_d       = err_q;
        req_valid   = 1'b0;
        ready_L2_L1 = 1'b0;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_commit  = 1'b0;

        same_addr  = (tag_L1_L2 == tag_q) && (index_L1_L2 == index_q);
        final_beat = (cnt_q == LAST_CNT);

        // hold releases as soon as the controller drops or moves the miss;
        // evaluated combinationally so a new address is accepted the same cycle
        if (flush || !read_L1_L2 || !same_addr) begin
            hold_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (read_L1_L2 && !flush && !(hold_q && same_addr)) begin
                    tag_d   = tag_L1_L2;
                    index_d = index_L1_L2;
                    way_d   = way;
                    hold_d  = 1'b0;
                    buf_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    // an accepted request must have its beats drained even on flush
                    cnt_d   = '0;
                    state_d = flush ? ST_DRAIN : ST_FILL;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (rsp_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!flush) begin
                        buf_wr = 1'b1;
                        if (rsp_last != final_beat) begin
                            err_d = 1'b1;
                        end
                        if (final_beat) begin
                            buf_commit = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end else begin
                        state_d = final_beat ? ST_IDLE : ST_DRAIN;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                ready_L2_L1 = !flush;
                hold_d      = !flush;
                state_d     = ST_IDLE;
            end
            ST_DRAIN: begin
                if (rsp_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (final_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            index_q <= '0;
            way_q   <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    l1_i_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CW)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (cnt_q),
        .wr_data (rsp_data),
        .commit  (buf_commit),
        .line_o  (line_L2_L1)
    );

    assign req_addr   = {tag_q, index_q};
    assign way_fill   = way_q;
    assign index_fill = index_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_l1_i_refill_unit.sv
// Scoreboard bench for l1_i_refill_unit: stimulus pushes expected requests
// and completed lines into queues; a negedge monitor pops and compares them
// whenever the DUT presents a request or a ready pulse.
module tb_l1_i_refill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_L1_L2;
    logic [17:0]  tag_L1_L2;
    logic [7:0]   index_L1_L2;
    logic         way;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [25:0]  req_addr;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_last;
    logic         ready_L2_L1;
    logic [511:0] line_L2_L1;
    logic         way_fill;
    logic [7:0]   index_fill;
    logic         busy;
    logic         err;

    l1_i_refill_unit #(
        .TNUM_2 (18),
        .INUM_2 (8),
        .LINE_W (512),
        .BEAT_W (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_L1_L2  (read_L1_L2),
        .tag_L1_L2   (tag_L1_L2),
        .index_L1_L2 (index_L1_L2),
        .way         (way),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .ready_L2_L1 (ready_L2_L1),
        .line_L2_L1  (line_L2_L1),
        .way_fill    (way_fill),
        .index_fill  (index_fill),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [511:0] line;
        logic         way;
        logic [7:0]   idx;
        logic         err;
    } fill_t;

    logic [25:0] exp_req_q[$];
    fill_t       exp_fill_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_starts = 0;
    int          ready_cnt = 0;
    int          ready_cyc = 0;
    logic        req_seen = 1'b0;
    logic [25:0] cur_req = '0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] bv(input logic [31:0] s, input logic [7:0] k);
        return {s, ~s, 32'h0BAD_F00D, 24'h0, k};
    endfunction

    function automatic logic [511:0] mkline(input logic [31:0] s);
        return {bv(s, 8'd3), bv(s, 8'd2), bv(s, 8'd1), bv(s, 8'd0)};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            req_seen = 1'b0;
        end else begin
            if (req_valid) begin
                if (!req_seen) begin
                    req_starts++;
                    chk("req_expected", exp_req_q.size() != 0, 1);
                    if (exp_req_q.size() != 0) cur_req = exp_req_q.pop_front();
                end
                chk("req_addr", req_addr, cur_req);
            end
            req_seen = req_valid && !req_ready;
            if (ready_L2_L1) begin
                fill_t f;
                ready_cnt++;
                ready_cyc = cyc;
                chk("fill_expected", exp_fill_q.size() != 0, 1);
                if (exp_fill_q.size() != 0) begin
                    f = exp_fill_q.pop_front();
                    chk("fill_line", line_L2_L1, f.line);
                    chk("fill_way", way_fill, f.way);
                    chk("fill_index", index_fill, f.idx);
                    chk("fill_err", err, f.err);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic last);
        rsp_valid = 1'b1;
        rsp_data  = d;
        rsp_last  = last;
        tick();
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
    endtask

    task automatic issue(input logic [17:0] t, input logic [7:0] i, input logic w);
        exp_req_q.push_back({t, i});
        read_L1_L2  = 1'b1;
        tag_L1_L2   = t;
        index_L1_L2 = i;
        way         = w;
    endtask

    task automatic expect_fill(input logic [511:0] l, input logic w, input logic [7:0] i, input logic e);
        fill_t f;
        f.line = l;
        f.way  = w;
        f.idx  = i;
        f.err  = e;
        exp_fill_q.push_back(f);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_req_valid"}, req_valid, 0);
        chk({tag, "_req_addr"}, req_addr, 0);
        chk({tag, "_ready"}, ready_L2_L1, 0);
        chk({tag, "_line"}, line_L2_L1, 0);
        chk({tag, "_way_fill"}, way_fill, 0);
        chk({tag, "_index_fill"}, index_fill, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int t0;
        int starts;
        logic [511:0] prior;

        rst = 1'b1; read_L1_L2 = 1'b0; tag_L1_L2 = '0; index_L1_L2 = '0; way = 1'b0;
        flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle_zero("reset");

        // basic fill, immediate req_ready, back-to-back beats
        req_ready = 1'b1;
        expect_fill(mkline(32'h11), 1'b1, 8'h13, 1'b0);
        issue(18'h2A5F1, 8'h13, 1'b1);
        t0 = cyc;
        tick();
        chk("t1_req_valid_T1", req_valid, 1);
        chk("t1_req_addr_T1", req_addr, 26'h2A5F113);
        tick();
        for (int k = 0; k < 4; k++) send_beat(bv(32'h11, 8'(k)), k == 3);
        tick();
        chk("t1_ready_cycle", ready_cyc, t0 + 6);
        chk("t1_ready_count", ready_cnt, 1);
        chk("t1_line_hold", line_L2_L1, mkline(32'h11));

        // held miss: same address stays asserted, no refetch
        starts = req_starts;
        repeat (10) tick();
        chk("t3_no_rereq", req_starts, starts);
        chk("t3_idle", busy, 0);
        expect_fill(mkline(32'h22), 1'b1, 8'h14, 1'b0);
        issue(18'h2A5F1, 8'h14, 1'b1);
        tick();
        chk("t3_new_req_next", req_valid, 1);
        tick();
        for (int k = 0; k < 4; k++) send_beat(bv(32'h22, 8'(k)), k == 3);
        read_L1_L2 = 1'b0;
        tick(); tick();
        chk("t3_ready_count", ready_cnt, 2);

        // stalled L2: req_ready late, gaps between beats
        req_ready = 1'b0;
        expect_fill(mkline(32'h33), 1'b0, 8'hA7, 1'b0);
        issue(18'h12345, 8'hA7, 1'b0);
        tick();
        repeat (5) tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat(bv(32'h33, 8'(k)), k == 3);
            if (k < 3) tick();
        end
        read_L1_L2 = 1'b0;
        tick(); tick();
        chk("t2_ready_count", ready_cnt, 3);
        chk("t2_err", err, 0);
        chk("t2_idle", busy, 0);
        prior = mkline(32'h33);

        // flush in FILL after beat 1, drain beats 2 and 3
        req_ready = 1'b1;
        issue(18'h00FFF, 8'h5C, 1'b1);
        tick(); tick();
        send_beat(bv(32'h44, 8'd0), 1'b0);
        send_beat(bv(32'h44, 8'd1), 1'b0);
        flush = 1'b1;
        read_L1_L2 = 1'b0;
        tick();
        flush = 1'b0;
        chk("t4_drain_busy_a", busy, 1);
        send_beat(bv(32'h44, 8'd2), 1'b0);
        chk("t4_drain_busy_b", busy, 1);
        send_beat(bv(32'h44, 8'd3), 1'b1);
        chk("t4_idle_after_drain", busy, 0);
        chk("t4_line_unchanged", line_L2_L1, prior);
        tick(); tick();
        chk("t4_no_ready", ready_cnt, 3);

        // protocol error: rsp_last on beat 1 only
        expect_fill(mkline(32'h55), 1'b0, 8'h01, 1'b1);
        issue(18'h3FFFF, 8'h01, 1'b0);
        tick(); tick();
        for (int k = 0; k < 4; k++) send_beat(bv(32'h55, 8'(k)), k == 1);
        read_L1_L2 = 1'b0;
        tick();
        repeat (3) tick();
        chk("t5_err_sticky", err, 1);
        chk("t5_ready_count", ready_cnt, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("t5_rst");

        // reset mid-FILL after beat 2
        issue(18'h2AAAA, 8'hF0, 1'b1);
        tick(); tick();
        for (int k = 0; k < 3; k++) send_beat(bv(32'h66, 8'(k)), 1'b0);
        rst = 1'b1;
        read_L1_L2 = 1'b0;
        tick();
        rst = 1'b0;
        check_idle_zero("t6_rst");
        send_beat(bv(32'h66, 8'd3), 1'b1);
        tick();
        check_idle_zero("t6_after");
        chk("t6_no_ready", ready_cnt, 4);

        chk("req_queue_drained", exp_req_q.size(), 0);
        chk("fill_queue_drained", exp_fill_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
